sram_req_ctrl: RTL and testbench

Valid/ready request front-end and read-response buffer for the 512x32 byte-masked single-port SRAM macro (1-cycle registered read, `dout` undefined after a write). Accepts one read or write per cycle from the core-side request channel, drives the macro pins directly, captures `dout` in the one cycle it is valid, and returns read data in order through a valid/ready response FIFO that tolerates arbitrary downstream backpressure.

---
 rtl/sram_req_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
//
// Core-side request front-end and in-order read-response buffer for a
// single-port, byte-masked SRAM macro with a 1-cycle registered read.
//
// Requests arrive on a valid/ready channel, one read or write per cycle, and
// are forwarded straight onto the macro pins. The macro's dout is sampled only
// in the single cycle after a read was accepted. Writes leave dout undefined,
// so it is never sampled then. Captured read data is queued in a small FIFO
// and returned on a valid/ready response channel. That channel may be
// back-pressured indefinitely.
//
// Flow control: req_ready is derived from registered state only. It is high
// while (buffered responses + reads in flight) is below RSP_DEPTH. Every read
// accepted therefore already owns a FIFO slot, and the FIFO cannot overflow.
//
// Ports
//   clk          in   clock, rising edge; also clocks the macro
//   rstb         in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request accepted when req_valid & req_ready at clk rise
//   req_we       in   1 = write, 0 = read
//   req_wmask    in   byte enables for writes
//   req_addr     in   word address
//   req_din      in   write data
//   rsp_valid    out  read data available at FIFO head
//   rsp_ready    in   consumer takes rsp_data when rsp_valid & rsp_ready
//   rsp_data     out  FIFO head data
//   sram_we      out  macro write enable
//   sram_wmask   out  macro byte mask
//   sram_addr    out  macro address
//   sram_din     out  macro write data
//   sram_dout    in   macro read data (valid one cycle after a read)
// -----------------------------------------------------------------------------
module sram_req_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 4,
   parameter int RSP_DEPTH   = 4     // legal range 2..16
) (
   input  logic                   clk,
   input  logic                   rstb,

   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WMASK_WIDTH-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_din,

   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_data,

   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                  rd_pending_reg, rd_pending_next;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];

   logic                  fire;
   logic                  wr_fire;
   logic                  push;
   logic                  pop;
   logic [OCC_W-1:0]      occupancy;

   // Pointers wrap modulo RSP_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // ------------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------------
   // A pending read counts as occupied because its data lands in the FIFO at
   // the next edge whether or not the consumer pops. rstb gates the output
   // directly, so req_ready drops as soon as reset is asserted.
   assign occupancy = OCC_W'(count_reg) + OCC_W'(rd_pending_reg);
   assign req_ready = rstb & (occupancy < OCC_W'(RSP_DEPTH));

   assign fire    = req_valid & req_ready;
   assign wr_fire = fire & req_we;

   // Address and data go to the macro unconditionally. Without a write fire,
   // the macro performs a harmless read whose result is never sampled.
   assign sram_addr  = req_addr;
   assign sram_din   = req_din;
   assign sram_we    = wr_fire;
   assign sram_wmask = wr_fire ? req_wmask : '0;

   // ------------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------------
   // dout is only meaningful in the cycle after a read fire.
   assign push      = rd_pending_reg;
   assign rsp_valid = (count_reg != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_data  = fifo_data[rd_ptr_reg];

   // One register per entry. Data carries no reset; an entry is only observed
   // after it has been written.
   generate
      for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] data_reg;

         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               data_reg <= sram_dout;
            end
         end

         assign fifo_data[gi] = data_reg;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Control: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      rd_pending_next = fire & ~req_we;
      count_next      = count_reg;
      wr_ptr_next     = wr_ptr_reg;
      rd_ptr_next     = rd_ptr_reg;

      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end

      // A simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // ------------------------------------------------------------------------
   // Control: state registers
   // ------------------------------------------------------------------------
   // Reset drops any read in flight and discards all buffered responses.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rd_pending_reg <= 1'b0;
         count_reg      <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
      end else begin
         rd_pending_reg <= rd_pending_next;
         count_reg      <= count_next;
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
      end
   end

`ifndef SYNTHESIS
   // The flow control reserves a slot for every accepted read. A push into a
   // full FIFO without a simultaneous pop would mean that reservation broke.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rstb)
      push |-> ((count_reg != CNT_W'(RSP_DEPTH)) || pop));

   a_occupancy_bound : assert property (@(posedge clk) disable iff (!rstb)
      occupancy <= OCC_W'(RSP_DEPTH));
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sram_req_ctrl.
//
// A behavioural 512x32 byte-masked macro is attached to the sram_* pins. Its
// dout is randomised after a write, so it is undefined data. A reference
// memory in the bench tracks accepted writes. Each accepted read pushes its
// expected data into a scoreboard queue. A monitor pops and compares that
// queue whenever the DUT hands over a response.
// -----------------------------------------------------------------------------
module tb_sram_req_ctrl;

   logic        clk;
   logic        rstb;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_wmask;
   logic [8:0]  req_addr;
   logic [31:0] req_din;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        sram_we;
   logic [3:0]  sram_wmask;
   logic [8:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   sram_req_ctrl dut (
      .clk        (clk),
      .rstb       (rstb),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_wmask  (req_wmask),
      .req_addr   (req_addr),
      .req_din    (req_din),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .sram_we    (sram_we),
      .sram_wmask (sram_wmask),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- macro model (preloads itself on its first edge) ------
   logic [31:0] mem [512];
   bit          loaded;

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 512; i++) mem[i] <= i * 32'h0101_0101;
         loaded <= 1'b1;
      end else if (sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         sram_dout <= $urandom;
      end else begin
         sram_dout <= mem[sram_addr];
      end
   end

   // ---------------- scoreboard ---------------------------------------------
   int          total;
   int          bad;
   int          rsp_cnt;
   logic [31:0] ref_mem [512];
   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;
   logic        last_ready;
   logic        last_fire;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstb && rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_rsp: got data %h expected no response", rsp_data);
         end else if (rsp_ready) begin
            mon_exp = exp_q.pop_front();
            check("rsp_data", rsp_data, mon_exp);
            rsp_cnt++;
            $display("rsp  data=%h exp=%h", rsp_data, mon_exp);
         end
      end
   end

   // Drive one cycle of request-channel inputs. Sample and check at negedge,
   // then return 1 ns after the next rising edge.
   task automatic do_req(input logic v, input logic we, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d,
                         input bit use_exp, input logic [31:0] e);
      req_valid = v;
      req_we    = we;
      req_wmask = m;
      req_addr  = a;
      req_din   = d;
      @(negedge clk);
      last_ready = req_ready;
      last_fire  = v & req_ready;
      check("sram_we", {31'd0, sram_we}, {31'd0, last_fire & we});
      check("sram_wmask", {28'd0, sram_wmask}, (last_fire & we) ? {28'd0, m} : 32'd0);
      check("sram_addr", {23'd0, sram_addr}, {23'd0, a});
      check("sram_din", sram_din, d);
      if (last_fire) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            $display("req  WR addr=%h mask=%b din=%h", a, m, d);
         end else begin
            exp_q.push_back(use_exp ? e : ref_mem[a]);
            $display("req  RD addr=%h", a);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      do_req(1'b0, 1'b0, 4'h0, 9'h000, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [8:0] a);
      do_req(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic wr(input logic [8:0] a, input logic [3:0] m, input logic [31:0] d);
      do_req(1'b1, 1'b1, m, a, d, 1'b0, 32'h0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
      check("drain_left", exp_q.size(), 0);
   endtask

   // ---------------- vector table -------------------------------------------
   typedef struct {
      logic        we;
      logic [3:0]  wmask;
      logic [8:0]  addr;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      tbl[0]  = '{1'b1, 4'hF,    9'h005, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{1'b0, 4'h0,    9'h005, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 4'b0101, 9'h005, 32'h1122_3344, 32'h0};
      tbl[3]  = '{1'b0, 4'h0,    9'h005, 32'h0,         32'hDE22_BE44};
      tbl[4]  = '{1'b1, 4'h0,    9'h005, 32'hFFFF_FFFF, 32'h0};
      tbl[5]  = '{1'b0, 4'h0,    9'h005, 32'h0,         32'hDE22_BE44};
      tbl[6]  = '{1'b0, 4'h0,    9'h1FF, 32'h0,         32'h0101_00FF};
      tbl[7]  = '{1'b1, 4'b1010, 9'h1FF, 32'h1234_5678, 32'h0};
      tbl[8]  = '{1'b0, 4'h0,    9'h1FF, 32'h0,         32'h1201_56FF};
      tbl[9]  = '{1'b0, 4'h0,    9'h000, 32'h0,         32'h0000_0000};
      tbl[10] = '{1'b0, 4'h0,    9'h007, 32'h0,         32'h0707_0707};
      tbl[11] = '{1'b1, 4'b0001, 9'h000, 32'h0000_00AA, 32'h0};
      tbl[12] = '{1'b0, 4'h0,    9'h000, 32'h0,         32'h0000_00AA};

      for (int i = 0; i < 512; i++) ref_mem[i] = i * 32'h0101_0101;
      total = 0; bad = 0; rsp_cnt = 0;

      // ---- reset state, with a write being offered ----
      rstb = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 9'h005; req_din = 32'h1;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_sram_we", {31'd0, sram_we}, 32'd0);
      check("rst_sram_wmask", {28'd0, sram_wmask}, 32'd0);
      req_valid = 1'b0;
      #1 rstb = 1'b1;
      #1 check("first_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;

      // ---- 16 back-to-back reads of preloaded words ----
      base = rsp_cnt;
      for (int i = 0; i < 16; i++) begin
         rd(9'(i));
         check("stream_ready", {31'd0, last_ready}, 32'd1);
         check("stream_rsp_cnt", rsp_cnt - base, (i >= 2) ? i - 1 : 0);
      end
      idle(); idle();
      check("stream_total", rsp_cnt - base, 16);

      // ---- write then read, 2-cycle latency ----
      wr(9'h005, 4'hF, 32'hDEAD_BEEF);
      do_req(1'b1, 1'b0, 4'h0, 9'h005, 32'h0, 1'b1, 32'hDEAD_BEEF);
      req_valid = 1'b0;
      check("lat_cycle1_valid", {31'd0, rsp_valid}, 32'd0);
      idle();
      check("lat_cycle2_valid", {31'd0, rsp_valid}, 32'd1);
      wait_drain();

      // ---- table vectors, one per cycle ----
      for (int i = 0; i < 13; i++)
         do_req(1'b1, tbl[i].we, tbl[i].wmask, tbl[i].addr, tbl[i].din, 1'b1, tbl[i].exp);
      wait_drain();

      // ---- backpressure: exactly 4 accepts, stable head, then drain ----
      rsp_ready = 1'b0;
      base = rsp_cnt;
      for (int i = 0; i < 6; i++) begin
         rd(9'h020 + 9'(i));
         check("bp_ready", {31'd0, last_ready}, (i < 4) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_hold_data", rsp_data, ref_mem[9'h020]);
      end
      rsp_ready = 1'b1;
      wait_drain();
      check("bp_drained", rsp_cnt - base, 4);
      idle();
      check("bp_ready_back", {31'd0, last_ready}, 32'd1);

      // ---- alternate write/read to the same address ----
      base = rsp_cnt;
      for (int i = 0; i < 8; i++) begin
         wr(9'h044, 4'hF, {16'hC0DE, 8'(i), ~8'(i)});
         rd(9'h044);
      end
      wait_drain();
      check("alt_rsp_count", rsp_cnt - base, 8);

      // ---- reset with 3 buffered and 1 pending ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) rd(9'h030 + 9'(i));
      check("pre_rst_ready", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 9'h031; req_din = 32'hBAD0_BAD0;
      #2 rstb = 1'b0;
      #1;
      check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("async_req_ready", {31'd0, req_ready}, 32'd0);
      check("async_sram_we", {31'd0, sram_we}, 32'd0);
      check("async_sram_wmask", {28'd0, sram_wmask}, 32'd0);
      exp_q.delete();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 rstb = 1'b1;
      #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      base = rsp_cnt;
      idle(); idle(); idle();
      rd(9'h031);
      wait_drain();
      check("post_rst_rsp_count", rsp_cnt - base, 1);
      idle(); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
